// File: rtl/game_pkg.sv
// Shared types and constants for the countdown/reaction game front-end.
package game_pkg;

  // Debounce FSM states
  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } db_state_t;

  // Board-level button wiring: 1 = pin reads low when pressed
  localparam bit BTN_ACTIVE_LOW = 1'b1;

  // Clock cycles per tick strobe
  function automatic int unsigned presc_of(input int unsigned clk_hz,
                                           input int unsigned tick_hz);
    return clk_hz / tick_hz;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running tick prescaler: internal strobe plus gated, registered tick_ms.
module tick_prescaler #(
  parameter int unsigned PRESC = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_en,
  input  logic tick_sync,
  output logic strobe,
  output logic tick_ms
);

  localparam int unsigned PW = $clog2(PRESC);
  localparam logic [PW-1:0] PLAST = PW'(PRESC - 1);

  logic [PW-1:0] pcnt;

  assign strobe = (pcnt == PLAST);

  // Phase counter: tick_sync realigns the phase ahead of the normal wrap
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pcnt <= '0;
    end else if (tick_sync || strobe) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

  // tick_ms follows the strobe one cycle later, gated only by tick_en
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick_ms <= 1'b0;
    end else begin
      tick_ms <= strobe & tick_en;
    end
  end

endmodule

// File: rtl/btn_tick_frontend.sv
// Button front-end: synchroniser, tick-based debounce FSM, press/release/long
// events and the millisecond tick strobe for the game FSM.
module btn_tick_frontend
  import game_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 10_000_000,
  parameter int unsigned TICK_HZ     = 1000,
  parameter int unsigned DEBOUNCE_MS = 5,
  parameter int unsigned LONG_MS     = 1000,
  parameter bit          ACTIVE_LOW  = BTN_ACTIVE_LOW
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  input  logic tick_en,
  input  logic tick_sync,
  output logic tick_ms,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press
);

  localparam int unsigned PRESC = presc_of(CLK_HZ, TICK_HZ);
  localparam int unsigned DW    = (DEBOUNCE_MS > 1) ? $clog2(DEBOUNCE_MS) : 1;
  localparam int unsigned HW    = $clog2(LONG_MS + 1);
  localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE_MS - 1);
  localparam logic [HW-1:0] HMAX  = HW'(LONG_MS);
  localparam logic [HW-1:0] HLAST = HW'(LONG_MS - 1);
  localparam logic IDLE_LVL = ACTIVE_LOW;

  logic          sync1, sync2;
  logic          s;
  logic          strobe;
  db_state_t     state, state_n;
  logic [DW-1:0] dcnt, dcnt_n;
  logic [HW-1:0] hcnt, hcnt_n;
  logic          level_n, press_n, release_n, long_n;

  tick_prescaler #(
    .PRESC(PRESC)
  ) u_presc (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick_en  (tick_en),
    .tick_sync(tick_sync),
    .strobe   (strobe),
    .tick_ms  (tick_ms)
  );

  // Two-flop synchroniser, reset to the idle pin level
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= IDLE_LVL;
      sync2 <= IDLE_LVL;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  // Normalised sample: 1 = pressed
  assign s = sync2 ^ IDLE_LVL;

  // Debounce next-state, counters and event decode
  always_comb begin
    state_n   = state;
    dcnt_n    = dcnt;
    hcnt_n    = hcnt;
    press_n   = 1'b0;
    release_n = 1'b0;
    long_n    = 1'b0;
    case (state)
      RELEASED: begin
        if (s) begin
          state_n = PRESS_WAIT;
          dcnt_n  = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_n = RELEASED;
        end else if (strobe) begin
          if (dcnt == DLAST) begin
            state_n = PRESSED;
            hcnt_n  = '0;
            press_n = 1'b1;
          end else begin
            dcnt_n = dcnt + 1'b1;
          end
        end
      end
      PRESSED: begin
        if (!s) begin
          state_n = RELEASE_WAIT;
          dcnt_n  = '0;
        end else if (strobe && (hcnt != HMAX)) begin
          hcnt_n = hcnt + 1'b1;
          long_n = (hcnt == HLAST);
        end
      end
      RELEASE_WAIT: begin
        if (s) begin
          state_n = PRESSED;
        end else if (strobe) begin
          if (dcnt == DLAST) begin
            state_n   = RELEASED;
            release_n = 1'b1;
          end else begin
            dcnt_n = dcnt + 1'b1;
          end
        end
      end
    endcase
    level_n = (state_n == PRESSED) || (state_n == RELEASE_WAIT);
  end

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= RELEASED;
      dcnt          <= '0;
      hcnt          <= '0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;
    end else begin
      state         <= state_n;
      dcnt          <= dcnt_n;
      hcnt          <= hcnt_n;
      btn_level     <= level_n;
      press_pulse   <= press_n;
      release_pulse <= release_n;
      long_press    <= long_n;
    end
  end

endmodule

// File: doc/btn_tick_frontend.md
Name: btn_tick_frontend

Overview:
Input front-end for the countdown/reaction game. It sits directly upstream of the game FSM.
- Synchronises and debounces the raw start/stop push-button (ui_in[0], active-low).
- Emits clean one-cycle press and release events, a debounced level and a long-press event.
- Generates the millisecond tick strobe that the game's countdown and display-hold timers consume.
- Replaces raw button sampling and free-running cycle counting in the game FSM.

Parameters:
CLK_HZ, 10_000_000, system clock frequency in Hz
TICK_HZ, 1000, tick strobe rate; PRESC = CLK_HZ/TICK_HZ, must be an integer >= 2
DEBOUNCE_MS, 5, number of consecutive ticks the input must be stable; >= 1
LONG_MS, 1000, number of ticks held in PRESSED before long_press fires; >= 1
ACTIVE_LOW, 1, 1 = btn_raw low means pressed

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
btn_raw  in  1  asynchronous raw button pin
tick_en  in  1  gates tick_ms output only
tick_sync  in  1  clears prescaler phase
tick_ms  out  1  one-cycle strobe every PRESC cycles while tick_en=1
btn_level  out  1  debounced state, 1 = pressed
press_pulse  out  1  one-cycle pulse on debounced press
release_pulse  out  1  one-cycle pulse on debounced release
long_press  out  1  one-cycle pulse, once per hold

Behaviour:
Reset (rst_n=0 at clk edge):
- All outputs are 0.
- Sync flops load the idle level (1 when ACTIVE_LOW).
- FSM goes to RELEASED; prescaler, debounce counter and hold counter are cleared.
- Reset mid-press: the held button is treated as a fresh press and reported after debounce.

Synchroniser:
- 2 flops. The value s is normalised to 1 = pressed before any use.
- 2-cycle input latency.

Prescaler:
- pcnt runs 0..PRESC-1 and wraps. It is free-running and independent of tick_en.
- strobe = (pcnt == PRESC-1).
- tick_sync=1 loads pcnt=0; tick_sync has priority over the increment.
- First strobe after reset or tick_sync occurs PRESC cycles later.
- tick_ms = registered (strobe & tick_en): it asserts the cycle after strobe.
- The debounce and hold logic use the internal strobe, never tick_ms.

Debounce FSM (states RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT):
- RELEASED: s=1 -> PRESS_WAIT, dcnt=0.
- PRESS_WAIT:
  - s=0 -> RELEASED (glitch rejected, no pulse).
  - else on strobe: if dcnt == DEBOUNCE_MS-1 -> PRESSED, press_pulse=1 next cycle, hcnt=0; otherwise dcnt++.
- PRESSED:
  - s=0 -> RELEASE_WAIT, dcnt=0.
  - On strobe with hcnt < LONG_MS: hcnt++. When hcnt reaches LONG_MS, long_press=1 for one cycle.
  - hcnt saturates at LONG_MS, so there is no repeat.
- RELEASE_WAIT:
  - s=1 -> PRESSED; no press_pulse, hcnt is held unchanged.
  - else on strobe: if dcnt == DEBOUNCE_MS-1 -> RELEASED, release_pulse=1 next cycle; otherwise dcnt++.
  - Strobes in this state do not advance hcnt.

Output timing and arithmetic:
- btn_level is registered: 1 iff state is PRESSED or RELEASE_WAIT.
- It rises in the same cycle as press_pulse and falls in the same cycle as release_pulse.
- Press latency from stable input = 2 sync cycles + between (DEBOUNCE_MS-1)*PRESC+1 and DEBOUNCE_MS*PRESC cycles + 1 output register.
- Counter widths are $clog2 of (max value + 1). No counter wraps.
- press_pulse, release_pulse and long_press are never asserted in the same cycle.

Decomposition:
- Shared package game_pkg holds:
  - debounce state typedef (2-bit enum)
  - the function computing PRESC
  - the active-level constant
- One sub-module, tick_prescaler, contains pcnt, tick_sync, strobe and the gated tick_ms register.
- Debounce FSM and counters stay in the top level.

Test Plan:
Common bench parameters: CLK_HZ=10000, TICK_HZ=1000 (PRESC=10), DEBOUNCE_MS=3, LONG_MS=20, ACTIVE_LOW=1.

1. Reset with btn_raw=1, tick_en=1 -> all outputs 0 during reset; tick_ms first high 11 cycles after rst_n rises, then every 10 cycles; tick_en=0 for 30 cycles -> no tick_ms.
2. Glitch: btn_raw=0 for 15 cycles, then 1 -> press_pulse, btn_level and release_pulse stay 0 throughout.
3. Clean press: btn_raw=0 held -> exactly one press_pulse 23..33 cycles after the falling edge; btn_level=1 from that cycle onward.
4. Long hold: keep btn_raw=0 for 300 cycles after press_pulse -> exactly one long_press, 200±10 cycles after press_pulse; no second pulse.
5. Release bounce: btn_raw=1 for 5 cycles, then 0 for 50 cycles, then 1 held -> no extra press_pulse, btn_level stays 1 through the bounce; exactly one release_pulse 23..33 cycles after the final rising edge; btn_level=0 in the same cycle.
6. tick_sync pulse at pcnt=6 -> next tick_ms 11 cycles later. Then rst_n=0 for 2 cycles while btn_raw=0 mid-hold -> outputs 0 the cycle after reset; a fresh press_pulse appears 25..35 cycles after rst_n rises.
